bus_invert_rx: RTL and testbench

//  Receive end of a bus-invert coded link. The transmitter sends W-bit words

---
 rtl/bus_invert_pkg.sv | 20 ++
 rtl/bi_skid_buffer.sv | 66 ++++++
 rtl/bus_invert_rx.sv | 71 +++++++
 tb/tb_bus_invert_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_invert_pkg.sv
// bus_invert_pkg: shared types, constants and the bus-invert decode helper.
//   INV_FLAG_W   width of the inversion flag carried alongside each word
//   MAX_W        widest data word the decode helper handles
//   skid_state_t occupancy of the 2-entry skid buffer
//   decode()     restores the true word from a coded word and its inv flag
package bus_invert_pkg;

    localparam int INV_FLAG_W = 1;
    localparam int MAX_W      = 64;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

    // Callers zero-extend into MAX_W and truncate the result back to their width;
    // the inverted upper bits are discarded by that truncation.
    function automatic logic [MAX_W-1:0] decode(input logic [MAX_W-1:0] data,
                                                input logic [INV_FLAG_W-1:0] inv);
        return inv[0] ? ~data : data;
    endfunction

endpackage

// File: rtl/bi_skid_buffer.sv
// bi_skid_buffer: 2-entry FIFO skid buffer behind a valid/ready handshake.
//   clk        rising-edge clock
//   reset      synchronous active-high reset, discards buffered words
//   in_data    word to store on push
//   in_valid   upstream word valid
//   in_ready   space available (registered state only, low during reset)
//   out_data   head entry
//   out_valid  buffer not empty
//   out_ready  downstream accepts the head entry
module bi_skid_buffer
    import bus_invert_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    skid_state_t  state;
    skid_state_t  state_nx;
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;

    assign in_ready  = (state != FULL) & ~reset;
    assign out_valid = (state != EMPTY);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   state_nx = push ? ONE : EMPTY;
            ONE:     state_nx = (push & ~pop) ? FULL : (pop & ~push) ? EMPTY : ONE;
            FULL:    state_nx = pop ? ONE : FULL;
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem    <= '{default: '0};
        end else begin
            state <= state_nx;
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: rtl/bus_invert_rx.sv
// bus_invert_rx: bus-invert link receiver; decodes words, buffers them, counts inversions.
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_data    coded word from the bus
//   in_inv     1 = in_data is inverted
//   in_valid   upstream word valid
//   in_ready   block can accept a word this cycle
//   out_data   decoded (true) word
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   inv_count  saturating count of accepted inverted words
//   in_par     even-parity bit over {in_inv,in_data}   (BUS_INVERT_PARITY_EN only)
//   par_err    sticky parity error, cleared by reset   (BUS_INVERT_PARITY_EN only)
module bus_invert_rx
    import bus_invert_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          in_data,
    input  logic [INV_FLAG_W-1:0] in_inv,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [W-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         inv_count
`ifdef BUS_INVERT_PARITY_EN
    ,
    input  logic                  in_par,
    output logic                  par_err
`endif
);

    logic         push;
    logic [W-1:0] decoded;

    assign push    = in_valid & in_ready;
    assign decoded = W'(decode(MAX_W'(in_data), in_inv));

    bi_skid_buffer #(.W(W)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .in_data   (decoded),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Saturates at all-ones so long-running statistics never wrap to a small value.
    always_ff @(posedge clk) begin
        if (reset)
            inv_count <= '0;
        else if (push && in_inv[0] && !(&inv_count))
            inv_count <= inv_count + 1'b1;
    end

`ifdef BUS_INVERT_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)
            par_err <= 1'b0;
        else if (push && (^{in_par, in_inv, in_data}))
            par_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_bus_invert_rx.sv
// tb_bus_invert_rx: directed self-checking bench for bus_invert_rx (W=8, CW=16 and CW=2).
module tb_bus_invert_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic [0:0] in_inv;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [15:0] inv_count;
    logic       in_ready2;
    logic [7:0] out_data2;
    logic       out_valid2;
    logic [1:0] inv_count2;
`ifdef BUS_INVERT_PARITY_EN
    logic       in_par;
    logic       par_err;
    logic       par_err2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_invert_rx #(.W(8), .CW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inv_count (inv_count)
`ifdef BUS_INVERT_PARITY_EN
        ,
        .in_par    (in_par),
        .par_err   (par_err)
`endif
    );

    bus_invert_rx #(.W(8), .CW(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .inv_count (inv_count2)
`ifdef BUS_INVERT_PARITY_EN
        ,
        .in_par    (in_par),
        .par_err   (par_err2)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_data = 8'h00; in_inv = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef BUS_INVERT_PARITY_EN
        in_par = 1'b0;
`endif
        reset = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++;
        if (inv_count !== 16'd0) begin failures++; $display("FAIL reset_inv_count got=%0d exp=0", inv_count); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_decode();
        in_data = 8'hA5; in_inv = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            failures++; $display("FAIL decode_inv got=%b/%h exp=1/5a", out_valid, out_data);
        end
        checks++;
        if (inv_count !== 16'd1) begin failures++; $display("FAIL decode_inv_count got=%0d exp=1", inv_count); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL decode_drain got=%b exp=0", out_valid); end
        in_data = 8'h3C; in_inv = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_data !== 8'h3C || inv_count !== 16'd1) begin
            failures++; $display("FAIL decode_plain got=%h/%0d exp=3c/1", out_data, inv_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 8'(i + 1);
            in_data = exp; in_inv = 1'b0; in_valid = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d got=%b/%h/%b exp=1/%h/1", i, out_valid, out_data, in_ready, exp);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_inv = 1'b0;
        in_data = 8'h10; in_valid = 1'b1;
        step();
        in_data = 8'h20;
        step();
        in_data = 8'h30;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        step();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 8'h10) begin
            failures++; $display("FAIL full_hold got=%b/%h exp=0/10", in_ready, out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h20 || in_ready !== 1'b1) begin
            failures++; $display("FAIL full_drain1 got=%b/%h/%b exp=1/20/1", out_valid, out_data, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h30) begin
            failures++; $display("FAIL full_drain2 got=%b/%h exp=1/30", out_valid, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp2 [5];
        exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        out_ready = 1'b1;
        in_inv = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'hF0 + i);
            step();
            checks++;
            if (inv_count2 !== exp2[i] || inv_count !== 16'(i + 1)) begin
                failures++;
                $display("FAIL sat_%0d got=%0d/%0d exp=%0d/%0d", i, inv_count2, inv_count, exp2[i], i + 1);
            end
        end
        in_valid = 1'b0; in_inv = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_data = 8'hAA; in_inv = 1'b0; in_valid = 1'b1;
        step();
        in_data = 8'h55; in_inv = 1'b1;
        step();
        in_valid = 1'b0; in_inv = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_data !== 8'hAA || inv_count !== 16'd6) begin
            failures++; $display("FAIL mid_full got=%b/%h/%0d exp=0/aa/6", in_ready, out_data, inv_count);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || inv_count !== 16'd0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/1", out_valid, inv_count, in_ready);
        end
        out_ready = 1'b1;
        in_data = 8'h77; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            failures++; $display("FAIL mid_after got=%b/%h exp=1/77", out_valid, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_empty got=%b exp=0", out_valid); end
    endtask

`ifdef BUS_INVERT_PARITY_EN
    task automatic test_parity();
        do_reset();
        checks++;
        if (par_err !== 1'b0) begin failures++; $display("FAIL par_reset got=%b exp=0", par_err); end
        out_ready = 1'b1;
        in_data = 8'h03; in_inv = 1'b0; in_par = 1'b0; in_valid = 1'b1;
        step();
        checks++;
        if (par_err !== 1'b0) begin failures++; $display("FAIL par_good got=%b exp=0", par_err); end
        in_data = 8'h01;
        step();
        in_valid = 1'b0;
        checks++;
        if (par_err !== 1'b1 || out_data !== 8'h01 || out_valid !== 1'b1) begin
            failures++; $display("FAIL par_bad got=%b/%h/%b exp=1/01/1", par_err, out_data, out_valid);
        end
        in_data = 8'h03; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (par_err !== 1'b1) begin failures++; $display("FAIL par_sticky got=%b exp=1", par_err); end
        do_reset();
        #1;
        checks++;
        if (par_err !== 1'b0) begin failures++; $display("FAIL par_clear got=%b exp=0", par_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_full();
        test_saturate();
        test_reset_mid();
`ifdef BUS_INVERT_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
